encipher_block: RTL and testbench

ENCIPHER_BLOCK -- requirements
Module: encipher_block

---
 rtl/aes_pkg.sv | 38 +++
 rtl/sbox.sv | 36 +++
 rtl/encipher_block.sv | 159 +++++++++++++++
 tb/tb_encipher_block.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: definitions shared by encipher_block and decipher_block.
//   - keylen codes and the matching round counts
//   - FSM state encoding for the iterative round engines
//   - GF(2^8) helpers (xtime, general multiply) over x^8+x^4+x^3+x+1
package aes_pkg;

    localparam logic [3:0] KEYLEN_128 = 4'd0;
    localparam logic [3:0] KEYLEN_192 = 4'd1;
    localparam logic [3:0] KEYLEN_256 = 4'd2;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

endpackage

// File: rtl/sbox.sv
// sbox: 32-bit combinational forward AES S-box, four parallel byte lookups.
//   word_i : 32-bit input word
//   word_o : SubBytes(word_i), byte lanes kept in place
module sbox (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Byte 0x00 occupies the top 8 bits, byte 0xff the bottom 8 bits.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            word_o[8*i +: 8] = SBOX_TABLE[2047 - 8*int'(word_i[8*i +: 8]) -: 8];
        end
    end

endmodule

// File: rtl/encipher_block.sv
// encipher_block: iterative AES encryption core (AES-128/192/256).
// Round keys come from an external key schedule indexed by round_number.
// Each round spends four cycles on SubBytes (one word per cycle through a
// single sbox) plus one cycle for ShiftRows/MixColumns/AddRoundKey.
//
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   next         : start pulse, honoured only in IDLE
//   keylen[3:0]  : 0=AES-128, 1=AES-192, 2=AES-256, others AES-128
//   round_number : round index for the external key schedule
//   round_key    : key for round_number, valid the same cycle
//   block        : plaintext, captured in the INIT cycle
//   new_block    : state words {w0,w1,w2,w3}, w0 = bits 127:96
//   ready        : new_block holds a finished ciphertext
//
// Build option: define AES_ENC_192_EN to enable AES-192 (keylen=1, 12 rounds);
// otherwise keylen=1 runs as AES-128.
//
// state | meaning
// IDLE  | waiting for next; outputs hold last result
// INIT  | initial AddRoundKey with round key 0
// SBOX  | SubBytes on word word_q, w0..w3 over four cycles
// MAIN  | ShiftRows/(MixColumns)/AddRoundKey; final round sets ready
module encipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [3:0]   keylen,
    output logic [3:0]   round_number,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    aes_state_e   state_q, state_d;
    logic [127:0] block_q, block_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   word_q, word_d;
    logic         ready_q, ready_d;
    logic [3:0]   nr;
    logic [31:0]  sbox_in, sbox_out;

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]),
                mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    always_comb begin
        nr = NR_128;
`ifdef AES_ENC_192_EN
        if (keylen == KEYLEN_192) nr = NR_192;
`endif
        if (keylen == KEYLEN_256) nr = NR_256;
    end

    always_comb begin
        case (word_q)
            2'd0:    sbox_in = block_q[127:96];
            2'd1:    sbox_in = block_q[95:64];
            2'd2:    sbox_in = block_q[63:32];
            default: sbox_in = block_q[31:0];
        endcase
    end

    sbox u_sbox (
        .word_i (sbox_in),
        .word_o (sbox_out)
    );

    always_comb begin
        state_d = state_q;
        block_d = block_q;
        round_d = round_q;
        word_d  = word_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (next) begin
                    round_d = 4'd0;
                    ready_d = 1'b0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                block_d = block ^ round_key;
                word_d  = 2'd0;
                round_d = 4'd1;
                state_d = ST_SBOX;
            end
            ST_SBOX: begin
                case (word_q)
                    2'd0:    block_d[127:96] = sbox_out;
                    2'd1:    block_d[95:64]  = sbox_out;
                    2'd2:    block_d[63:32]  = sbox_out;
                    default: block_d[31:0]   = sbox_out;
                endcase
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) state_d = ST_MAIN;
            end
            ST_MAIN: begin
                if (round_q < nr) begin
                    block_d = mix_columns(shift_rows(block_q)) ^ round_key;
                    round_d = round_q + 4'd1;
                    state_d = ST_SBOX;
                end else begin
                    block_d = shift_rows(block_q) ^ round_key;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            block_q <= '0;
            round_q <= 4'd0;
            word_q  <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            round_q <= round_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

    assign round_number = round_q;
    assign new_block    = block_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_encipher_block.sv
module tb_encipher_block;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic [3:0]   keylen;
    logic [3:0]   round_number;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    int checks = 0;
    int errors = 0;

    logic [127:0] rk_tb [0:15];
    logic [7:0]   sb_tb [0:255];

    always #5 clk = ~clk;

    // External key schedule: key for the requested round, same cycle.
    assign round_key = rk_tb[round_number];

    encipher_block dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .next         (next),
        .keylen       (keylen),
        .round_number (round_number),
        .round_key    (round_key),
        .block        (block),
        .new_block    (new_block),
        .ready        (ready)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
            end
            sb_tb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tb[w[31:24]], sb_tb[w[23:16]], sb_tb[w[15:8]], sb_tb[w[7:0]]};
    endfunction

    function automatic int eff_nr(input logic [3:0] kl);
        if (kl == 4'd2) return 14;
`ifdef AES_ENC_192_EN
        if (kl == 4'd1) return 12;
`endif
        return 10;
    endfunction

    // Standard key expansion; key is left-aligned in 256 bits, Nk = Nr - 6 words used.
    task automatic load_keys(input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_tb[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tb[r] = '0;
        end
    endtask

    // Byte-array AES: byte i sits at row i%4, column i/4.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        logic [127:0] k;
        k = rk_tb[0];
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            k = rk_tb[r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One encryption; next pulses at cycles pa/pb of the operation (negative: none).
    task automatic run_op(input string tag, input logic [255:0] key, input logic [3:0] kl,
                          input logic [127:0] pt, input logic [127:0] exp_ct,
                          input int pa, input int pb);
        int nr;
        int cnt;
        logic [127:0] held;
        nr = eff_nr(kl);
        load_keys(key, nr);
        @(negedge clk);
        keylen = kl;
        block  = pt;
        next   = 1'b1;
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        next = 1'b0;
        check_val({tag, "_ready_fall"}, 128'(ready), 128'd0);
        @(posedge clk);
        cnt = 2;
        @(negedge clk);
        block = rand128();
        while (!ready && cnt < 200) begin
            next = (cnt == pa || cnt == pb);
            @(posedge clk);
            cnt++;
            @(negedge clk);
            next = 1'b0;
        end
        check_val({tag, "_latency"}, 128'(cnt), 128'(2 + 5*nr));
        check_val({tag, "_ct"}, new_block, exp_ct);
        held = new_block;
        repeat (3) @(negedge clk);
        check_val({tag, "_hold_ready"}, 128'(ready), 128'd1);
        check_val({tag, "_hold_ct"}, new_block, held);
    endtask

    task automatic abort_op(input logic [255:0] key, input logic [127:0] pt, input int at);
        load_keys(key, 10);
        @(negedge clk);
        keylen = 4'd0;
        block  = pt;
        next   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        next = 1'b0;
        repeat (at - 1) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("abort_new_block", new_block, 128'd0);
        check_val("abort_ready", 128'(ready), 128'd0);
        check_val("abort_round", 128'(round_number), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check_val("abort_stays_idle_ready", 128'(ready), 128'd0);
        check_val("abort_stays_idle_block", new_block, 128'd0);
    endtask

    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEYFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT1     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PTFIPS  = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [255:0] rkey;
        logic [127:0] rpt;
        logic [127:0] rexp;
        logic [3:0]   rkl;
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 4'd0;
        block   = '0;
        for (int r = 0; r < 16; r++) rk_tb[r] = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        check_val("reset_ready", 128'(ready), 128'd0);
        check_val("reset_new_block", new_block, 128'd0);
        check_val("reset_round", 128'(round_number), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("aes128", KEY128, 4'd0, PT1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, -1);
        run_op("aes256", KEY256, 4'd2, PT1, 128'h8ea2b7ca516745bfeafc49904b496089, -1, -1);
`ifdef AES_ENC_192_EN
        run_op("aes192", KEY192, 4'd1, PT1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, -1, -1);
`else
        run_op("aes192", KEY192, 4'd1, PT1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, -1);
`endif
        run_op("fips", KEYFIPS, 4'd0, PTFIPS, 128'h3925841d02dc09fbdc118597196a0b32, -1, -1);
        run_op("kl7_pulses", KEYFIPS, 4'd7, PTFIPS, 128'h3925841d02dc09fbdc118597196a0b32, 10, 30);

        abort_op(KEY128, PT1, 20);
        run_op("post_reset", KEYFIPS, 4'd0, PTFIPS, 128'h3925841d02dc09fbdc118597196a0b32, -1, -1);

        for (int i = 0; i < 6; i++) begin
            rkey = {rand128(), rand128()};
            rpt  = rand128();
            rkl  = (i < 3) ? 4'(i) : 4'($urandom_range(0, 15));
            load_keys(rkey, eff_nr(rkl));
            rexp = ref_encrypt(rpt, eff_nr(rkl));
            run_op($sformatf("rnd%0d", i), rkey, rkl, rpt, rexp, 5 + i, 17 + 2*i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
